// File: rtl/instr_aligner_pkg.sv
// instr_aligner_pkg: shared types and helpers for the fetch-to-decode instruction aligner
package instr_aligner_pkg;
  localparam int PARCEL_W = 16;
  localparam int FETCH_XLEN = 64;
  typedef logic [31:0] aligned_instr_t;
  typedef enum logic {RUN, HALT} state_e;
  typedef struct packed {
    logic                fault;
    logic [PARCEL_W-1:0] data;
  } parcel_t;
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [63:0]           data;
    logic                  fault;
  } fetch_block_t;
  function automatic logic is_compressed(input logic [PARCEL_W-1:0] p);
    return p[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/instr_aligner_parcel_fifo.sv
// parcel_fifo: circular parcel buffer, pushes 0..4 parcels at the tail and pops 0..2 at the head
module parcel_fifo
  import instr_aligner_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic [2:0]        i_push_n,
  input  parcel_t [3:0]     i_push,
  input  logic [1:0]        i_pop_n,
  output parcel_t           o_head0,
  output parcel_t           o_head1,
  output logic [CW-1:0]     o_count
);
  parcel_t mem_q [DEPTH];
  parcel_t mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  // write the incoming parcels in order from the tail and advance both pointers
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < 4; k++)
      if (3'(k) < i_push_n) mem_d[tail_q + AW'(k)] = i_push[k];
    head_d  = i_flush ? '0 : head_q + AW'(i_pop_n);
    tail_d  = i_flush ? '0 : tail_q + AW'(i_push_n);
    count_d = i_flush ? '0 : count_q + CW'(i_push_n) - CW'(i_pop_n);
  end
  // pointer and occupancy registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // parcel storage carries no reset; occupancy decides what is meaningful
  always_ff @(posedge i_clk) mem_q <= mem_d;
  assign o_head0 = mem_q[head_q];
  assign o_head1 = mem_q[head_q + AW'(1)];
  assign o_count = count_q;
endmodule

// File: rtl/instr_aligner.sv
// instr_aligner: turns 64-bit fetch blocks into one aligned 16/32-bit instruction per cycle
module instr_aligner
  import instr_aligner_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_fetch_valid,
  output logic            o_fetch_ready,
  input  logic [XLEN-1:0] i_fetch_pc,
  input  logic [63:0]     i_fetch_data,
  input  logic            i_fetch_fault,
  output logic            o_valid,
  input  logic            i_ready,
  output aligned_instr_t  o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic            o_compressed,
  output logic            o_fault
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e state_q, state_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d, tail_pc;
  parcel_t [3:0] push;
  parcel_t head0, head1;
  logic [CW-1:0] count, remain;
  logic [2:0] push_n;
  logic [1:0] pop_n, off;
  logic [63:0] shifted;
  logic comp, has2, fire, accept;
  parcel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_flush  (i_flush),
    .i_push_n (push_n),
    .i_push   (push),
    .i_pop_n  (pop_n),
    .o_head0  (head0),
    .o_head1  (head1),
    .o_count  (count)
  );
  // handshake, output formatting and push/pop sizing; flush and HALT silence both sides
  always_comb begin
    off           = i_fetch_pc[2:1];
    shifted       = i_fetch_data >> {off, 4'b0};
    has2          = count >= CW'(2);
    comp          = is_compressed(head0.data);
    o_fetch_ready = (state_q == RUN) & ~i_flush & (count <= CW'(DEPTH - 4));
    o_valid       = (state_q == RUN) & ~i_flush & (count != '0) & (comp | has2 | head0.fault);
    o_compressed  = o_valid & comp;
    o_instr       = !o_valid ? '0 : comp ? {16'h0, head0.data} : {has2 ? head1.data : 16'h0, head0.data};
    o_pc          = o_valid ? head_pc_q : '0;
    o_fault       = o_valid & (head0.fault | (~comp & has2 & head1.fault));
    fire          = o_valid & i_ready;
    pop_n         = (fire & ~o_fault) ? (comp ? 2'd1 : 2'd2) : 2'd0;
    accept        = i_fetch_valid & o_fetch_ready;
    push_n        = accept ? 3'd4 - {1'b0, off} : 3'd0;
    for (int k = 0; k < 4; k++) push[k] = '{fault: i_fetch_fault, data: shifted[16*k +: 16]};
    remain        = count - CW'(pop_n);
    tail_pc       = head_pc_q + XLEN'({count, 1'b0});
  end
  // next state and head PC: a fault halts until flush; an empty buffer re-seeds the PC from fetch
  always_comb begin
    state_d   = i_flush ? RUN : (fire & o_fault) ? HALT : state_q;
    head_pc_d = head_pc_q + XLEN'({pop_n, 1'b0});
    if (accept & (remain == '0)) head_pc_d = i_fetch_pc & ~XLEN'(1);
  end
  // state and head PC registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= RUN;
      head_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      head_pc_q <= head_pc_d;
    end
  end
  a_contiguous: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (accept && count != '0) |-> ((i_fetch_pc & ~XLEN'(1)) == tail_pc));
endmodule
